// File: rtl/iob_split_tmo_pkg.sv
`default_nettype none
// Shared state encoding, width helpers and default error word for the timeout-aware IOb splitter.
package iob_split_tmo_pkg;

   localparam logic [1:0]  ST_IDLE      = 2'd0;
   localparam logic [1:0]  ST_PEND      = 2'd1;
   localparam logic [1:0]  ST_FLUSH     = 2'd2;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int m);
      return $clog2(m + 1);
   endfunction

   function automatic int tmo_w(input int t);
      return (t > 2) ? $clog2(t) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/iob_split_tmo_trk.sv
`default_nettype none
// Outstanding-read tracker: ordering FSM, read counter, response timeout,
// sticky dead-slave flags and registered error responses.
module iob_split_tmo_trk
   import iob_split_tmo_pkg::*;
#(
   parameter int N_SLAVES = 2,
   parameter int MAX_OUT  = 4,
   parameter int TIMEOUT  = 1024,
   parameter int SEL_W    = sel_w(N_SLAVES)
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                cke,
   input  logic                m_valid,
   input  logic                is_read,
   input  logic [SEL_W-1:0]    sel,
   input  logic                sel_ok,
   input  logic                ready_sel,
   input  logic [N_SLAVES-1:0] s_rvalid,
   output logic                m_ready,
   output logic                s_go,
   output logic                rsp,
   output logic                err_rvalid,
   output logic                err_flag,
   output logic [SEL_W-1:0]    pend_sel,
   output logic [N_SLAVES-1:0] dead
);

   localparam int CNT_W = cnt_w(MAX_OUT);
   localparam int TMO_W = tmo_w(TIMEOUT);
   localparam int SEL_N = 2 ** SEL_W;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [TMO_W-1:0] tmo_ctr;
   logic [SEL_N-1:0] dead_pad;
   logic [SEL_N-1:0] rv_pad;
   logic             bad;
   logic             full;
   logic             allow;
   logic             rd_acc;
   logic             bad_acc;
   logic             tmo_hit;

   assign dead_pad = SEL_N'(dead);
   assign rv_pad   = SEL_N'(s_rvalid);

   always_comb begin
      bad     = !sel_ok || dead_pad[sel];
      rsp     = (state == ST_PEND) && rv_pad[pend_sel];
      // A response in the same cycle frees a slot, so a full queue can still take a read.
      full    = is_read && (cnt == CNT_W'(MAX_OUT)) && !rsp;
      allow   = (state == ST_IDLE) || ((state == ST_PEND) && (sel == pend_sel) && !full);
      m_ready = bad ? (state == ST_IDLE) : (ready_sel && allow);
      s_go    = m_valid && !bad && allow;
      rd_acc  = s_go && ready_sel && is_read;
      bad_acc = m_valid && bad && (state == ST_IDLE);
      tmo_hit = (TIMEOUT != 0) && (state == ST_PEND) && !rd_acc && !rsp &&
                (tmo_ctr == TMO_W'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         pend_sel   <= '0;
         tmo_ctr    <= '0;
         dead       <= '0;
         err_rvalid <= 1'b0;
         err_flag   <= 1'b0;
      end else if (cke) begin
         err_rvalid <= 1'b0;
         err_flag   <= 1'b0;
         case (state)
            ST_IDLE: begin
               tmo_ctr <= '0;
               if (rd_acc) begin
                  state    <= ST_PEND;
                  pend_sel <= sel;
                  cnt      <= CNT_W'(1);
               end
               if (bad_acc) begin
                  err_rvalid <= is_read;
                  err_flag   <= 1'b1;
               end
            end
            ST_PEND: begin
               if (tmo_hit) begin
                  state   <= ST_FLUSH;
                  dead    <= dead | (N_SLAVES'(1) << pend_sel);
                  tmo_ctr <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(rd_acc) - CNT_W'(rsp);
                  if (rd_acc || rsp)
                     tmo_ctr <= '0;
                  else if (TIMEOUT != 0)
                     tmo_ctr <= tmo_ctr + TMO_W'(1);
                  if (rsp && !rd_acc && (cnt == CNT_W'(1)))
                     state <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               // One error response per cycle for each read the dead slave still owes.
               err_rvalid <= 1'b1;
               err_flag   <= 1'b1;
               cnt        <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/iob_split_tmo.sv
`default_nettype none
// IOb one-to-N splitter: address-field select decode and request/response muxing
// around the outstanding-read tracker.
module iob_split_tmo
   import iob_split_tmo_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                N_SLAVES = 2,
   parameter int                P_SLAVES = ADDR_W - 2,
   parameter int                MAX_OUT  = 4,
   parameter int                TIMEOUT  = 1024,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
   input  logic                           clk_i,
   input  logic                           arst_n_i,
   input  logic                           cke_i,
   input  logic                           m_valid_i,
   input  logic [ADDR_W-1:0]              m_addr_i,
   input  logic [DATA_W-1:0]              m_wdata_i,
   input  logic [DATA_W/8-1:0]            m_wstrb_i,
   output logic                           m_ready_o,
   output logic [DATA_W-1:0]              m_rdata_o,
   output logic                           m_rvalid_o,
   output logic                           m_err_o,
   output logic [N_SLAVES-1:0]            s_valid_o,
   output logic [N_SLAVES*ADDR_W-1:0]     s_addr_o,
   output logic [N_SLAVES*DATA_W-1:0]     s_wdata_o,
   output logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb_o,
   input  logic [N_SLAVES*DATA_W-1:0]     s_rdata_i,
   input  logic [N_SLAVES-1:0]            s_rvalid_i,
   input  logic [N_SLAVES-1:0]            s_ready_i,
   output logic [N_SLAVES-1:0]            dead_o
);

   localparam int SEL_W = sel_w(N_SLAVES);
   localparam int SEL_N = 2 ** SEL_W;

   logic [SEL_W-1:0]  sel;
   logic [SEL_W-1:0]  pend_sel;
   logic [SEL_N-1:0]  rdy_pad;
   logic              sel_ok;
   logic              ready_sel;
   logic              s_go;
   logic              rsp;
   logic              err_rvalid;
   logic              err_flag;
   logic [DATA_W-1:0] rsp_data;

   assign sel       = m_addr_i[P_SLAVES -: SEL_W];
   assign rdy_pad   = SEL_N'(s_ready_i);
   assign ready_sel = rdy_pad[sel];

   generate
      if (N_SLAVES == SEL_N) begin : g_sel_full
         assign sel_ok = 1'b1;
      end else begin : g_sel_part
         assign sel_ok = {1'b0, sel} < (SEL_W + 1)'(N_SLAVES);
      end
   endgenerate

   iob_split_tmo_trk #(
      .N_SLAVES (N_SLAVES),
      .MAX_OUT  (MAX_OUT),
      .TIMEOUT  (TIMEOUT),
      .SEL_W    (SEL_W)
   ) u_trk (
      .clk        (clk_i),
      .arst_n     (arst_n_i),
      .cke        (cke_i),
      .m_valid    (m_valid_i),
      .is_read    (m_wstrb_i == '0),
      .sel        (sel),
      .sel_ok     (sel_ok),
      .ready_sel  (ready_sel),
      .s_rvalid   (s_rvalid_i),
      .m_ready    (m_ready_o),
      .s_go       (s_go),
      .rsp        (rsp),
      .err_rvalid (err_rvalid),
      .err_flag   (err_flag),
      .pend_sel   (pend_sel),
      .dead       (dead_o)
   );

   always_comb begin
      rsp_data = '0;
      for (int i = 0; i < N_SLAVES; i++)
         if (pend_sel == SEL_W'(i))
            rsp_data = s_rdata_i[i*DATA_W +: DATA_W];
   end

   assign s_valid_o  = s_go ? (N_SLAVES'(1) << sel) : '0;
   assign s_addr_o   = {N_SLAVES{m_addr_i}};
   assign s_wdata_o  = {N_SLAVES{m_wdata_i}};
   assign s_wstrb_o  = {N_SLAVES{m_wstrb_i}};
   assign m_rvalid_o = err_rvalid || rsp;
   assign m_rdata_o  = err_rvalid ? ERR_DATA : rsp_data;
   assign m_err_o    = err_flag;

endmodule
`default_nettype wire

// File: doc/iob_split_tmo.md
Name: iob_split_tmo

Overview:
Parametrised successor of the IOb bus splitter. It routes one IOb master to N_SLAVES slaves using an address select field, and tracks outstanding reads up to a configurable depth. It adds a per-slave response timeout with sticky dead-slave marking, plus error responses for timed-out, dead or unmapped targets. It sits on the CPU data/instruction split paths and on the peripheral bus, where a hung peripheral must not hang the CPU.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
N_SLAVES, 2, number of slave ports, 1..16
P_SLAVES, ADDR_W-2, MSB position of the select field; SEL_W = max(1, clog2(N_SLAVES)); sel = m_addr_i[P_SLAVES -: SEL_W]
MAX_OUT, 4, maximum outstanding reads, 1..15
TIMEOUT, 1024, cycles without a response before timeout; 0 disables the timeout
ERR_DATA, 32'hDEADBEEF, rdata returned on any error read

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
cke_i  in  1  clock enable; all state holds when low
m_valid_i  in  1  master request valid
m_addr_i  in  ADDR_W  master address
m_wdata_i  in  DATA_W  write data
m_wstrb_i  in  DATA_W/8  write strobes; all zero means read
m_ready_o  out  1  request accepted this cycle
m_rdata_o  out  DATA_W  read data
m_rvalid_o  out  1  read data valid
m_err_o  out  1  error flag: qualifies an error rvalid, or a one-cycle pulse after an errored write
s_valid_o  out  N_SLAVES  per-slave request valid
s_addr_o  out  N_SLAVES*ADDR_W  address, passed through unchanged
s_wdata_o  out  N_SLAVES*DATA_W  write data, broadcast
s_wstrb_o  out  N_SLAVES*DATA_W/8  write strobes, broadcast
s_rdata_i  in  N_SLAVES*DATA_W  slave read data
s_rvalid_i  in  N_SLAVES  slave read valid
s_ready_i  in  N_SLAVES  slave request accepted
dead_o  out  N_SLAVES  sticky per-slave timeout flags

Behaviour:
- Reset (arst_n_i=0): state IDLE; cnt=0; pend_sel=0; tmo_ctr=0; dead_o=0; m_rvalid_o=0; m_err_o=0. Combinational outputs follow from these values, so s_valid_o=0 unless m_valid_i is high.
- Read accept: m_valid_i & m_ready_o with wstrb=0. Write accept: the same with wstrb≠0. Writes produce no rvalid.
- A target is bad when sel>=N_SLAVES or dead_o[sel]=1. A bad target never drives s_valid_o.
- Good-target request path is combinational, zero latency: s_valid_o[sel]=m_valid_i & allow; m_ready_o=s_ready_i[sel] & allow.
- allow = (state==IDLE) | (state==PEND & sel==pend_sel & !(read & cnt==MAX_OUT)).
  - Requests to a different slave stall until cnt=0, which keeps responses in order.
  - Writes follow the same rule.
- Response path: m_rvalid_o/m_rdata_o = s_rvalid_i/s_rdata_i[pend_sel] when state==PEND. s_rvalid_i from any other slave, or while not in PEND, is ignored (orphans).
- States:
  - IDLE (cnt=0).
    - Good read accept → PEND, pend_sel=sel, cnt=1.
    - Bad read → m_ready_o=1 the same cycle; registered response next cycle: m_rvalid_o=1, m_rdata_o=ERR_DATA, m_err_o=1; state stays IDLE.
    - Bad write → m_ready_o=1, data dropped, m_err_o pulses next cycle.
  - PEND. Per cycle, cnt += read_accept - s_rvalid_i[pend_sel]; a simultaneous accept and response leaves cnt unchanged. cnt reaching 0 → IDLE. Bad targets in PEND stall.
  - FLUSH. Entered when tmo_ctr==TIMEOUT-1 with no response that cycle.
    - On entry, dead_o[pend_sel] is set.
    - One registered error rvalid (ERR_DATA, m_err_o=1) is emitted per cycle, decrementing cnt. m_ready_o=0 throughout.
    - cnt=0 → IDLE. Late responses from the dead slave are dropped.
- tmo_ctr clears on any read accept or s_rvalid_i[pend_sel]. It increments in PEND otherwise and is inactive when TIMEOUT=0.
- rdata to the master is never modified on good responses. Counter widths: cnt is clog2(MAX_OUT+1) bits; tmo_ctr is clog2(TIMEOUT) bits, with no wrap because it saturates at the threshold.
- dead_o clears only on reset.

Decomposition:
- Package iob_split_tmo_pkg:
  - state encoding (IDLE=0, PEND=1, FLUSH=2)
  - SEL_W / CNT_W / TMO_W width functions
  - ERR_DATA default
- Sub-module iob_split_tmo_trk: holds cnt, pend_sel, tmo_ctr, FSM and dead_o, and emits allow and error responses. The top level holds only the select decode and the muxes.

Test Plan:
1. N=3, P=31. Read 0x4000_0010 (sel=1); slave1 returns 0x1234_5678 two cycles later → m_rvalid_o=1, m_rdata_o=0x12345678, m_err_o=0, FSM back in IDLE.
2. MAX_OUT=4. Five back-to-back reads to slave0 with rvalid held off → reads 1-4 accepted; the 5th sees m_ready_o=0 until the first rvalid, then is accepted the same cycle (cnt stays 4).
3. Read slave0 pending, then a write to slave2 → s_valid_o[2]=0 and m_ready_o=0 until slave0 rvalid; the write is issued the cycle after cnt reaches 0.
4. TIMEOUT=16. Two reads to slave1, which never responds → after 16 idle cycles dead_o[1]=1; two consecutive error rvalids with 0xDEADBEEF and m_err_o=1. A subsequent read to slave1 gets its error rvalid 1 cycle after accept, s_valid_o[1] stays 0, and a late s_rvalid_i[1] is ignored.
5. N=3. Read with sel=3 → m_ready_o=1, error rvalid next cycle. Write with sel=3 → accepted, m_err_o pulses for 1 cycle, no s_valid_o asserted.
6. Assert arst_n_i=0 mid-PEND with cnt=2 and dead_o[1]=1 → cnt=0, dead_o=0, IDLE. A late s_rvalid_i[0] after release produces no m_rvalid_o.
